// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller and its stage registers.
package fetch_pkg;

    localparam int unsigned AddrWDefault  = 12;
    localparam int unsigned InstWDefault  = 19;
    localparam int unsigned ResetPcDefault = 0;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StDebug,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register holding valid/inst/pc, with hold and flush enables.
module if_id_reg #(
    parameter int unsigned AddrW = 12,
    parameter int unsigned InstW = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic [InstW-1:0] inst_i,
    input  logic [AddrW-1:0] pc_i,
    output logic             valid_o,
    output logic [InstW-1:0] inst_o,
    output logic [AddrW-1:0] pc_o
);

    logic             valid_d, valid_q;
    logic [InstW-1:0] inst_d, inst_q;
    logic [AddrW-1:0] pc_d, pc_q;

    // Flush only kills the valid bit; payload keeps its last value.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!hold_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, loads IF/ID, and time-shares the
// instruction memory read port with a debug read port.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = AddrWDefault,
    parameter int unsigned INST_W   = InstWDefault,
    parameter int unsigned RESET_PC = ResetPcDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic [INST_W-1:0] dbg_data,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              dbg_gnt_d, dbg_gnt_q;
    logic [INST_W-1:0] dbg_data_d, dbg_data_q;
    logic              ifid_hold, ifid_flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dbg_gnt_d  = 1'b0;
        dbg_data_d = dbg_data_q;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        imem_addr  = pc_q;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                // A FETCH cycle with dbg_gnt_q high directly follows DEBUG, so no grant here.
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (halt_req) begin
                    state_d    = StHalted;
                    ifid_flush = 1'b1;
                end else if (dbg_req && !dbg_gnt_q) begin
                    state_d    = StDebug;
                    ifid_flush = !stall;
                end else if (!stall) begin
                    ifid_hold = 1'b0;
                    pc_d      = pc_q + ADDR_W'(1);
                end
            end
            StDebug: begin
                imem_addr  = dbg_addr;
                dbg_gnt_d  = 1'b1;
                dbg_data_d = imem_data;
                state_d    = StFetch;
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else begin
                    ifid_flush = !stall;
                end
            end
            StHalted: begin
                imem_addr  = dbg_addr;
                ifid_flush = 1'b1;
                if (dbg_req) begin
                    dbg_gnt_d  = 1'b1;
                    dbg_data_d = imem_data;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= ResetPc;
            dbg_gnt_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dbg_gnt_q  <= dbg_gnt_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    if_id_reg #(
        .AddrW(ADDR_W),
        .InstW(INST_W)
    ) u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (ifid_hold),
        .flush_i(ifid_flush),
        .inst_i (imem_data),
        .pc_i   (pc_q),
        .valid_o(if_valid),
        .inst_o (if_inst),
        .pc_o   (if_pc)
    );

    assign dbg_gnt  = dbg_gnt_q;
    assign dbg_data = dbg_data_q;
    assign halted   = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 19;
    localparam int unsigned NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt_req = 1'b0;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_gnt;
    logic [IW-1:0] dbg_data;
    logic          if_valid;
    logic [IW-1:0] if_inst;
    logic [AW-1:0] if_pc;
    logic          halted;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer #(
        .ADDR_W  (AW),
        .INST_W  (IW),
        .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_gnt       (dbg_gnt),
        .dbg_data      (dbg_data),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Memory word k holds k.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a);
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: booting / in a debug slot / halted, plus architectural registers.
    bit          m_booting, m_in_dbg, m_halted, m_after_dbg;
    logic [AW-1:0] m_pc;
    bit          m_v;
    logic [IW-1:0] m_inst, m_data;
    logic [AW-1:0] m_ifpc;
    bit          m_gnt;

    task automatic model_reset();
        m_booting = 1; m_in_dbg = 0; m_halted = 0; m_after_dbg = 0;
        m_pc = '0; m_v = 0; m_inst = '0; m_ifpc = '0; m_gnt = 0; m_data = '0;
    endtask

    function automatic logic [AW-1:0] model_addr();
        return (m_in_dbg || m_halted) ? dbg_addr : m_pc;
    endfunction

    task automatic model_step();
        logic [IW-1:0] rd;
        bit            was_dbg;
        rd = mem_word(model_addr());
        was_dbg = m_in_dbg;
        m_gnt = 0;
        if (m_booting) begin
            m_booting = 0;
        end else if (m_halted) begin
            if (dbg_req) begin m_gnt = 1; m_data = rd; end
        end else if (m_in_dbg) begin
            m_gnt = 1; m_data = rd; m_in_dbg = 0;
            if (redirect_valid) begin m_pc = redirect_pc; m_v = 0; end
            else if (!stall) m_v = 0;
        end else begin
            if (redirect_valid) begin
                m_pc = redirect_pc; m_v = 0;
            end else if (halt_req) begin
                m_halted = 1; m_v = 0;
            end else if (dbg_req && !m_after_dbg) begin
                m_in_dbg = 1;
                if (!stall) m_v = 0;
            end else if (!stall) begin
                m_inst = rd; m_ifpc = m_pc; m_v = 1; m_pc = m_pc + 1'b1;
            end
        end
        m_after_dbg = was_dbg;
    endtask

    task automatic check_outputs();
        check_eq("imem_addr", 32'(imem_addr), 32'(model_addr()));
        check_eq("if_valid", 32'(if_valid), 32'(m_v));
        if (m_v) begin
            check_eq("if_inst", 32'(if_inst), 32'(m_inst));
            check_eq("if_pc", 32'(if_pc), 32'(m_ifpc));
        end
        check_eq("dbg_gnt", 32'(dbg_gnt), 32'(m_gnt));
        check_eq("dbg_data", 32'(dbg_data), 32'(m_data));
        check_eq("halted", 32'(halted), 32'(m_halted));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        stall = 0; redirect_valid = 0; halt_req = 0; dbg_req = 0;
        #1;
        model_reset();
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check_eq("rst_dbg_data", 32'(dbg_data), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int next_rst;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        next_rst = 150 + int'($urandom_range(200));
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Requester: drops on grant, sometimes immediately starts a new request.
            if (m_gnt) begin
                if ($urandom_range(1) == 1) dbg_addr = AW'($urandom);
                else dbg_req = 1'b0;
            end else if (!dbg_req && $urandom_range(7) == 0) begin
                dbg_req  = 1'b1;
                dbg_addr = AW'($urandom);
            end
            stall          = ($urandom_range(4) == 0);
            redirect_valid = ($urandom_range(9) == 0);
            redirect_pc    = ($urandom_range(2) == 0) ? AW'(12'hFFD) : AW'($urandom);
            halt_req       = ($urandom_range(119) == 0);
            #1;
            check_outputs();
            next_rst--;
            if (next_rst <= 0 || (m_gnt && !m_halted && $urandom_range(15) == 0)) begin
                do_reset();
                next_rst = 150 + int'($urandom_range(200));
            end else begin
                model_step();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
